// File: rtl/dual_input_debouncer.sv
// dual_input_debouncer
//   Two independent channels, each made of a synchronizer chain, a 4-state
//   debounce FSM and a stability counter. The block produces clean levels for
//   the a/b inputs of downstream 2-input gates.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   a_raw, b_raw   raw asynchronous switch inputs
//   a, b           debounced levels (registered)
//   a_busy, b_busy channel FSM is in WAIT_HI or WAIT_LO
//   a_edge, b_edge one-cycle pulse when a/b changes
//
// Build option:
//   DEBOUNCE_EDGE_PULSE_EN  when defined, a_edge/b_edge are registered pulses
//                           aligned with the output change. When undefined,
//                           no edge flops are built and both ports read 0.
module dual_input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_busy,
  output logic b_busy,
  output logic a_edge,
  output logic b_edge
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_e;

  logic [1:0] raw_v;
  logic [1:0] out_v;
  logic [1:0] busy_v;
  logic [1:0] edge_v;

  assign raw_v = {b_raw, a_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   s;

    // Only the last synchronizer stage is ever seen by the FSM.
    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw_v[ch]};
    end

    // The output level is updated on the same transition that enters the
    // STABLE state, so it comes from a flop rather than a state decode.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      unique case (state_q)
        STABLE_LO: begin
          if (s) begin
            state_d = WAIT_HI;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            out_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state_d = WAIT_LO;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (s) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            out_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          out_d   = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= '0;
        state_q <= STABLE_LO;
        cnt_q   <= '0;
        out_q   <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
      end
    end

    assign out_v[ch]  = out_q;
    assign busy_v[ch] = (state_q == WAIT_HI) || (state_q == WAIT_LO);

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic edge_q, edge_d;

    always_comb begin
      edge_d = out_d ^ out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        edge_q <= 1'b0;
      end else begin
        edge_q <= edge_d;
      end
    end

    assign edge_v[ch] = edge_q;
`else
    assign edge_v[ch] = 1'b0;
`endif
  end

  assign a      = out_v[0];
  assign b      = out_v[1];
  assign a_busy = busy_v[0];
  assign b_busy = busy_v[1];
  assign a_edge = edge_v[0];
  assign b_edge = edge_v[1];

endmodule
